// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control FSM for the MIPS-subset CPU: sequences each instruction through
// FETCH/DECODE/EXE/MEM/WB, drives the ALU op code and datapath write enables.
module alu_ctrl_fsm #(
    parameter int unsigned ST_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       ZF,
    input  logic       OF,
    output logic [5:0] ALUCtrl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [1:0] PCSrc,
    output logic       PCWr,
    output logic       IRWr,
    output logic       MemWr,
    output logic       RegWr,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       OvErr
);

    typedef enum logic [ST_W-1:0] {
        StFetch,
        StDecode,
        StExe,
        StMemRd,
        StMemWr,
        StWb,
        StBranch,
        StJump
    } state_e;

    // ALU operation codes
    localparam logic [5:0] AluAddu = 6'b000000;
    localparam logic [5:0] AluSubu = 6'b000001;
    localparam logic [5:0] AluAdd  = 6'b000100;
    localparam logic [5:0] AluSub  = 6'b000101;
    localparam logic [5:0] AluAnd  = 6'b001000;
    localparam logic [5:0] AluOr   = 6'b001001;
    localparam logic [5:0] AluXor  = 6'b001011;
    localparam logic [5:0] AluSlt  = 6'b001110;
    localparam logic [5:0] AluNull = 6'b111111;

    // Opcodes
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    // R-type function codes
    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnAddu = 6'b100001;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnSubu = 6'b100011;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnXor  = 6'b100110;
    localparam logic [5:0] FnSlt  = 6'b101010;

    state_e state_q, state_d;
    logic   ovf_q;
    logic   overr_q;

    logic       is_rtype, is_addi, is_addiu, is_andi, is_ori, is_lw, is_sw, is_beq, is_j;
    logic       is_ialu, goes_exe;
    logic [5:0] r_alu;
    logic       r_valid;
    logic       ovf_chk;
    logic       wb_valid;
    logic [5:0] exe_alu;
    logic [1:0] exe_srcb;
    logic       exe_ext;

    assign is_rtype = (Op == OpRtype);
    assign is_addi  = (Op == OpAddi);
    assign is_addiu = (Op == OpAddiu);
    assign is_andi  = (Op == OpAndi);
    assign is_ori   = (Op == OpOri);
    assign is_lw    = (Op == OpLw);
    assign is_sw    = (Op == OpSw);
    assign is_beq   = (Op == OpBeq);
    assign is_j     = (Op == OpJ);
    assign is_ialu  = is_addi | is_addiu | is_andi | is_ori;
    assign goes_exe = is_rtype | is_ialu | is_lw | is_sw;

    always_comb begin
        r_alu   = AluNull;
        r_valid = 1'b1;
        unique case (Funct)
            FnAdd:   r_alu = AluAdd;
            FnAddu:  r_alu = AluAddu;
            FnSub:   r_alu = AluSub;
            FnSubu:  r_alu = AluSubu;
            FnAnd:   r_alu = AluAnd;
            FnOr:    r_alu = AluOr;
            FnXor:   r_alu = AluXor;
            FnSlt:   r_alu = AluSlt;
            default: r_valid = 1'b0;
        endcase
    end

    // Only the trapping add/sub forms may block writeback on overflow.
    assign ovf_chk  = (is_rtype & ((Funct == FnAdd) | (Funct == FnSub))) | is_addi;
    assign wb_valid = (is_rtype & r_valid) | is_ialu | is_lw;

    always_comb begin
        exe_alu  = AluNull;
        exe_srcb = 2'b00;
        exe_ext  = 1'b0;
        if (is_rtype) begin
            exe_alu = r_alu;
        end else if (is_addi) begin
            exe_alu  = AluAdd;
            exe_srcb = 2'b10;
            exe_ext  = 1'b1;
        end else if (is_addiu || is_lw || is_sw) begin
            exe_alu  = AluAddu;
            exe_srcb = 2'b10;
            exe_ext  = 1'b1;
        end else if (is_andi) begin
            exe_alu  = AluAnd;
            exe_srcb = 2'b10;
        end else if (is_ori) begin
            exe_alu  = AluOr;
            exe_srcb = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            ovf_q   <= 1'b0;
            overr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StExe) begin
                ovf_q <= OF & ovf_chk;
            end
            if ((state_q == StWb) && ovf_q) begin
                overr_q <= 1'b1;
            end
        end
    end

    // Outputs are held inactive while reset is asserted, even though the state reads FETCH.
    always_comb begin
        state_d  = state_q;
        ALUCtrl  = AluNull;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ExtOp    = 1'b0;
        PCSrc    = 2'b00;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        MemWr    = 1'b0;
        RegWr    = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    ALUCtrl = AluAddu;
                    ALUSrcB = 2'b01;
                    PCWr    = 1'b1;
                    IRWr    = 1'b1;
                    state_d = StDecode;
                end
                StDecode: begin
                    ALUCtrl = AluAddu;
                    ALUSrcB = 2'b11;
                    ExtOp   = 1'b1;
                    if (goes_exe) begin
                        state_d = StExe;
                    end else if (is_beq) begin
                        state_d = StBranch;
                    end else if (is_j) begin
                        state_d = StJump;
                    end else begin
                        state_d = StFetch;
                    end
                end
                StExe: begin
                    ALUSrcA = 1'b1;
                    ALUCtrl = exe_alu;
                    ALUSrcB = exe_srcb;
                    ExtOp   = exe_ext;
                    if (is_lw) begin
                        state_d = StMemRd;
                    end else if (is_sw) begin
                        state_d = StMemWr;
                    end else begin
                        state_d = StWb;
                    end
                end
                StMemRd: begin
                    state_d = StWb;
                end
                StMemWr: begin
                    MemWr   = 1'b1;
                    state_d = StFetch;
                end
                StWb: begin
                    RegWr    = ~ovf_q & wb_valid;
                    RegDst   = is_rtype;
                    MemToReg = is_lw;
                    state_d  = StFetch;
                end
                StBranch: begin
                    ALUSrcA = 1'b1;
                    ALUCtrl = AluSubu;
                    PCSrc   = 2'b01;
                    PCWr    = ZF;
                    state_d = StFetch;
                end
                StJump: begin
                    PCSrc   = 2'b10;
                    PCWr    = 1'b1;
                    state_d = StFetch;
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    assign OvErr = overr_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Scoreboard bench for alu_ctrl_fsm: the driver queues the expected output word for every
// cycle of each instruction; a negedge monitor pops and compares.
module tb_alu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       ZF;
    logic       OF;
    logic [5:0] ALUCtrl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic [1:0] PCSrc;
    logic       PCWr;
    logic       IRWr;
    logic       MemWr;
    logic       RegWr;
    logic       RegDst;
    logic       MemToReg;
    logic       OvErr;

    int total = 0;
    int bad   = 0;

    logic [18:0] expq[$];
    string       nameq[$];

    alu_ctrl_fsm #(.ST_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .Op      (Op),
        .Funct   (Funct),
        .ZF      (ZF),
        .OF      (OF),
        .ALUCtrl (ALUCtrl),
        .ALUSrcA (ALUSrcA),
        .ALUSrcB (ALUSrcB),
        .ExtOp   (ExtOp),
        .PCSrc   (PCSrc),
        .PCWr    (PCWr),
        .IRWr    (IRWr),
        .MemWr   (MemWr),
        .RegWr   (RegWr),
        .RegDst  (RegDst),
        .MemToReg(MemToReg),
        .OvErr   (OvErr)
    );

    always #5 clk = ~clk;

    // Word layout: ALUCtrl | SrcA SrcB ExtOp PCSrc | PCWr IRWr MemWr RegWr | RegDst MemToReg | OvErr
    logic [18:0] mon_act, mon_exp;
    string       mon_name;
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_exp  = expq.pop_front();
            mon_name = nameq.pop_front();
            mon_act  = {ALUCtrl, ALUSrcA, ALUSrcB, ExtOp, PCSrc, PCWr, IRWr, MemWr, RegWr,
                        RegDst, MemToReg, OvErr};
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                $display("FAIL %s: got %b_%b_%b expected %b_%b_%b", mon_name,
                         mon_act[18:13], mon_act[12:1], mon_act[0],
                         mon_exp[18:13], mon_exp[12:1], mon_exp[0]);
            end
        end
    end

    task automatic push(input string name, input logic [5:0] alu, input logic [11:0] ctl,
                        input logic oe);
        expq.push_back({alu, ctl, oe});
        nameq.push_back(name);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sets the instruction fields and queues the common FETCH and DECODE cycles.
    task automatic start(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic zf, input logic of, input logic oe);
        Op    = op;
        Funct = fn;
        ZF    = zf;
        OF    = of;
        push({name, "_fetch"}, 6'b000000, 12'b0_01_0_00_1100_00, oe);
        push({name, "_decode"}, 6'b000000, 12'b0_11_1_00_0000_00, oe);
    endtask

    // Four-cycle ALU instruction: FETCH, DECODE, EXE, WB.
    task automatic alu_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic of, input logic [5:0] exe_alu,
                             input logic [11:0] exe_ctl, input logic [11:0] wb_ctl,
                             input logic oe);
        start(name, op, fn, 1'b1, of, oe);
        push({name, "_exe"}, exe_alu, exe_ctl, oe);
        push({name, "_wb"}, 6'b111111, wb_ctl, oe);
        cycles(4);
    endtask

    initial begin
        rst   = 1'b1;
        Op    = 6'b0;
        Funct = 6'b0;
        ZF    = 1'b0;
        OF    = 1'b0;
        push("reset_hold", 6'b111111, 12'b0_00_0_00_0000_00, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // add with OF=1 abandoned by a reset pulse in EXE
        start("rst_add", 6'b000000, 6'b100000, 1'b0, 1'b1, 1'b0);
        cycles(2);
        push("rst_add_exe", 6'b111111, 12'b0_00_0_00_0000_00, 1'b0);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;

        // R-type
        alu_instr("addu", 6'b000000, 6'b100001, 1'b1, 6'b000000, 12'b1_00_0_00_0000_00,
                  12'b0_00_0_00_0001_10, 1'b0);
        alu_instr("add_ovf", 6'b000000, 6'b100000, 1'b1, 6'b000100, 12'b1_00_0_00_0000_00,
                  12'b0_00_0_00_0000_10, 1'b0);
        alu_instr("addu_after", 6'b000000, 6'b100001, 1'b1, 6'b000000,
                  12'b1_00_0_00_0000_00, 12'b0_00_0_00_0001_10, 1'b1);
        alu_instr("sub", 6'b000000, 6'b100010, 1'b0, 6'b000101, 12'b1_00_0_00_0000_00,
                  12'b0_00_0_00_0001_10, 1'b1);
        alu_instr("subu", 6'b000000, 6'b100011, 1'b1, 6'b000001, 12'b1_00_0_00_0000_00,
                  12'b0_00_0_00_0001_10, 1'b1);
        alu_instr("and", 6'b000000, 6'b100100, 1'b0, 6'b001000, 12'b1_00_0_00_0000_00,
                  12'b0_00_0_00_0001_10, 1'b1);
        alu_instr("or", 6'b000000, 6'b100101, 1'b0, 6'b001001, 12'b1_00_0_00_0000_00,
                  12'b0_00_0_00_0001_10, 1'b1);
        alu_instr("xor", 6'b000000, 6'b100110, 1'b0, 6'b001011, 12'b1_00_0_00_0000_00,
                  12'b0_00_0_00_0001_10, 1'b1);
        alu_instr("slt", 6'b000000, 6'b101010, 1'b0, 6'b001110, 12'b1_00_0_00_0000_00,
                  12'b0_00_0_00_0001_10, 1'b1);
        alu_instr("bad_funct", 6'b000000, 6'b111111, 1'b0, 6'b111111,
                  12'b1_00_0_00_0000_00, 12'b0_00_0_00_0000_10, 1'b1);

        // I-type ALU
        alu_instr("addi_ovf", 6'b001000, 6'b000000, 1'b1, 6'b000100,
                  12'b1_10_1_00_0000_00, 12'b0_00_0_00_0000_00, 1'b1);
        alu_instr("addi", 6'b001000, 6'b000000, 1'b0, 6'b000100, 12'b1_10_1_00_0000_00,
                  12'b0_00_0_00_0001_00, 1'b1);
        alu_instr("addiu", 6'b001001, 6'b000000, 1'b1, 6'b000000, 12'b1_10_1_00_0000_00,
                  12'b0_00_0_00_0001_00, 1'b1);
        alu_instr("andi", 6'b001100, 6'b000000, 1'b0, 6'b001000, 12'b1_10_0_00_0000_00,
                  12'b0_00_0_00_0001_00, 1'b1);
        alu_instr("ori", 6'b001101, 6'b000000, 1'b0, 6'b001001, 12'b1_10_0_00_0000_00,
                  12'b0_00_0_00_0001_00, 1'b1);

        // lw (OF ignored), 5 cycles
        start("lw", 6'b100011, 6'b000000, 1'b0, 1'b1, 1'b1);
        push("lw_exe", 6'b000000, 12'b1_10_1_00_0000_00, 1'b1);
        push("lw_memrd", 6'b111111, 12'b0_00_0_00_0000_00, 1'b1);
        push("lw_wb", 6'b111111, 12'b0_00_0_00_0001_01, 1'b1);
        cycles(5);

        // sw, 4 cycles
        start("sw", 6'b101011, 6'b000000, 1'b0, 1'b0, 1'b1);
        push("sw_exe", 6'b000000, 12'b1_10_1_00_0000_00, 1'b1);
        push("sw_memwr", 6'b111111, 12'b0_00_0_00_0010_00, 1'b1);
        cycles(4);

        // beq taken / not taken, 3 cycles each
        start("beq_t", 6'b000100, 6'b000000, 1'b1, 1'b0, 1'b1);
        push("beq_t_branch", 6'b000001, 12'b1_00_0_01_1000_00, 1'b1);
        cycles(3);
        start("beq_nt", 6'b000100, 6'b000000, 1'b0, 1'b1, 1'b1);
        push("beq_nt_branch", 6'b000001, 12'b1_00_0_01_0000_00, 1'b1);
        cycles(3);

        // j, 3 cycles
        start("j", 6'b000010, 6'b000000, 1'b0, 1'b0, 1'b1);
        push("j_jump", 6'b111111, 12'b0_00_0_10_1000_00, 1'b1);
        cycles(3);

        // unknown opcode, 2 cycles
        start("bad_op", 6'b111111, 6'b000000, 1'b0, 1'b0, 1'b1);
        cycles(2);

        Op = 6'b000000;
        push("final_fetch", 6'b000000, 12'b0_01_0_00_1100_00, 1'b1);
        cycles(1);

        for (int i = 0; i < 10 && expq.size() > 0; i++) begin
            @(posedge clk);
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
